// File: rtl/ootx_multi_frame_decoder.sv
// OOTX frame decoder for several independent lighthouse bitstreams.
// Each channel hunts for the 17-zero preamble, strips sync bits, captures
// length/payload/CRC, checks CRC32 and commits good frames to a readout bank.
// Banks and counters are read through an Avalon-MM slave with read latency 1.
module ootx_multi_frame_decoder #(
   parameter int NUM_LIGHTHOUSES   = 2,
   parameter int MAX_PAYLOAD_BYTES = 33,
   parameter int ADDR_WIDTH        = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_LIGHTHOUSES-1:0] bit_valid,
   input  logic [NUM_LIGHTHOUSES-1:0] bit_data,
   input  logic [ADDR_WIDTH-1:0]      address,
   input  logic                       read,
   output logic [31:0]                readdata,
   input  logic                       write,
   input  logic [31:0]                writedata,
   output logic                       waitrequest,
   output logic [NUM_LIGHTHOUSES-1:0] frame_done,
   output logic [NUM_LIGHTHOUSES-1:0] frame_error
);

   // Payload storage is rounded up to whole 16-bit words so the pad byte fits.
   localparam int          PB      = ((MAX_PAYLOAD_BYTES + 1) / 2) * 2;
   localparam int          PIW     = $clog2(PB);
   localparam logic [5:0]  PB_B    = 6'(PB);
   localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD_BYTES);

   typedef enum logic [2:0] {HUNT, LENGTH, PAYLOAD, CRC, CHECK} state_t;

   // One reflected CRC32 byte step, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'b0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   logic [ADDR_WIDTH-1:0]        ch_sel;
   logic [3:0]                   off;
   logic [NUM_LIGHTHOUSES*32-1:0] ch_word;
   logic [NUM_LIGHTHOUSES-1:0]   clr;
   logic [31:0]                  readdata_q, readdata_d;
   logic                         unused_wdata;

   assign ch_sel       = address >> 4;
   assign off          = address[3:0];
   assign waitrequest  = 1'b0;
   assign readdata     = readdata_q;
   assign unused_wdata = ^writedata[31:1];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LIGHTHOUSES; gi++) begin : gen_ch
         state_t      state_q, state_d;
         logic [4:0]  zero_cnt_q, zero_cnt_d;
         logic [4:0]  bit_cnt_q, bit_cnt_d;
         logic [6:0]  shift_q, shift_d;
         logic [5:0]  byte_idx_q, byte_idx_d;
         logic [15:0] len_q, len_d;
         logic [31:0] crc_q, crc_d, crc_rx_q, crc_rx_d;
         logic [7:0]  stage_q [PB];
         logic [7:0]  stage_d [PB];
         logic        bank_valid_q, bank_valid_d;
         logic [15:0] frame_cnt_q, frame_cnt_d, bank_len_q, bank_len_d;
         logic [7:0]  crc_err_q, crc_err_d, sync_err_q, sync_err_d, len_err_q, len_err_d;
         logic [31:0] bank_crc_q, bank_crc_d;
         logic [7:0]  bank_pay_q [PB];
         logic [7:0]  bank_pay_d [PB];
         logic        pend_done_q, pend_done_d, pend_crc_q, pend_crc_d;
         logic        pend_sync_q, pend_sync_d, pend_len_q, pend_len_d;
         logic        frame_done_q, frame_done_d, frame_error_q, frame_error_d;
         logic        a_done, a_crc, a_sync, a_len;
         logic        preamble, in_frame, ev_sync, ev_len, ev_done, ev_crc;
         logic [7:0]  byte_v;
         logic [5:0]  kb;
         logic [31:0] rd_word;
         logic        unused_bits;

         assign in_frame    = (state_q == LENGTH) || (state_q == PAYLOAD) || (state_q == CRC);
         assign preamble    = bit_valid[gi] && bit_data[gi] && (zero_cnt_q >= 5'd17);
         assign byte_v      = {shift_q, bit_data[gi]};
         assign clr[gi]     = write && writedata[0] && (off == 4'd0) && (ch_sel == ADDR_WIDTH'(gi));
         assign unused_bits = ^{sync_err_q[7:4], len_err_q[7:3]};

         // FSM state register
         always_ff @(posedge clock) begin
            if (reset) state_q <= HUNT;
            else       state_q <= state_d;
         end

         // Next state; a preamble restarts the frame from any state
         always_comb begin
            state_d = state_q;
            ev_sync = 1'b0;
            ev_len  = 1'b0;
            if (preamble) begin
               state_d = LENGTH;
               ev_sync = in_frame;
            end else if (bit_valid[gi] && in_frame && (bit_cnt_q == 5'd16)) begin
               if (!bit_data[gi]) begin
                  state_d = HUNT;
                  ev_sync = 1'b1;
               end else begin
                  case (state_q)
                     LENGTH: begin
                        if ((len_q == 16'd0) || (len_q > MAX_LEN)) begin
                           state_d = HUNT;
                           ev_len  = 1'b1;
                        end else begin
                           state_d = PAYLOAD;
                        end
                     end
                     PAYLOAD: if ({10'b0, byte_idx_q} >= len_q) state_d = CRC;
                     CRC:     if (byte_idx_q == 6'd4) state_d = CHECK;
                     default: state_d = state_q;
                  endcase
               end
            end else if (state_q == CHECK) begin
               state_d = HUNT;
            end
         end

         // CRC verdict, only meaningful in the single CHECK cycle
         always_comb begin
            ev_done = (state_q == CHECK) && (~crc_q == crc_rx_q);
            ev_crc  = (state_q == CHECK) && (~crc_q != crc_rx_q);
         end

         // Bit-level datapath: zero run, word shifting, byte capture, running CRC
         always_comb begin
            zero_cnt_d = zero_cnt_q;
            bit_cnt_d  = bit_cnt_q;
            shift_d    = shift_q;
            byte_idx_d = byte_idx_q;
            len_d      = len_q;
            crc_d      = crc_q;
            crc_rx_d   = crc_rx_q;
            stage_d    = stage_q;
            if (bit_valid[gi]) begin
               if (bit_data[gi])              zero_cnt_d = 5'd0;
               else if (zero_cnt_q != 5'd17)  zero_cnt_d = zero_cnt_q + 5'd1;
            end
            if (preamble) begin
               bit_cnt_d  = 5'd0;
               byte_idx_d = 6'd0;
               len_d      = 16'd0;
               crc_d      = 32'hFFFF_FFFF;
            end else if (bit_valid[gi] && in_frame) begin
               if (bit_cnt_q == 5'd16) begin
                  bit_cnt_d = 5'd0;
                  if (state_d != state_q) byte_idx_d = 6'd0;
               end else begin
                  shift_d   = {shift_q[5:0], bit_data[gi]};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if ((bit_cnt_q == 5'd7) || (bit_cnt_q == 5'd15)) begin
                     byte_idx_d = byte_idx_q + 6'd1;
                     case (state_q)
                        LENGTH: len_d[8*byte_idx_q[0] +: 8] = byte_v;
                        PAYLOAD: begin
                           if (byte_idx_q < PB_B) stage_d[PIW'(byte_idx_q)] = byte_v;
                           // the odd pad byte is stored but kept out of the CRC
                           if ({10'b0, byte_idx_q} < len_q) crc_d = crc32_byte(crc_q, byte_v);
                        end
                        CRC:     crc_rx_d[8*byte_idx_q[1:0] +: 8] = byte_v;
                        default: byte_idx_d = byte_idx_q;
                     endcase
                  end
               end
            end
         end

         // Datapath registers
         always_ff @(posedge clock) begin
            if (reset) begin
               zero_cnt_q <= '0;
               bit_cnt_q  <= '0;
               shift_q    <= '0;
               byte_idx_q <= '0;
               len_q      <= '0;
               crc_q      <= '0;
               crc_rx_q   <= '0;
               stage_q    <= '{default: '0};
            end else begin
               zero_cnt_q <= zero_cnt_d;
               bit_cnt_q  <= bit_cnt_d;
               shift_q    <= shift_d;
               byte_idx_q <= byte_idx_d;
               len_q      <= len_d;
               crc_q      <= crc_d;
               crc_rx_q   <= crc_rx_d;
               stage_q    <= stage_d;
            end
         end

         // Bank/counter update; a software clear wins and defers any coincident event by a cycle
         always_comb begin
            a_done        = ev_done | pend_done_q;
            a_crc         = ev_crc  | pend_crc_q;
            a_sync        = ev_sync | pend_sync_q;
            a_len         = ev_len  | pend_len_q;
            pend_done_d   = a_done & clr[gi];
            pend_crc_d    = a_crc  & clr[gi];
            pend_sync_d   = a_sync & clr[gi];
            pend_len_d    = a_len  & clr[gi];
            frame_done_d  = a_done & ~clr[gi];
            frame_error_d = (a_crc | a_sync | a_len) & ~clr[gi];
            bank_valid_d  = bank_valid_q;
            frame_cnt_d   = frame_cnt_q;
            crc_err_d     = crc_err_q;
            sync_err_d    = sync_err_q;
            len_err_d     = len_err_q;
            bank_len_d    = bank_len_q;
            bank_crc_d    = bank_crc_q;
            bank_pay_d    = bank_pay_q;
            if (clr[gi]) begin
               bank_valid_d = 1'b0;
               frame_cnt_d  = 16'd0;
               crc_err_d    = 8'd0;
               sync_err_d   = 8'd0;
               len_err_d    = 8'd0;
            end else begin
               if (a_done) begin
                  bank_valid_d = 1'b1;
                  frame_cnt_d  = frame_cnt_q + 16'd1;
                  bank_len_d   = len_q;
                  bank_crc_d   = crc_rx_q;
                  bank_pay_d   = stage_q;
               end
               if (a_crc  && (crc_err_q  != 8'hFF)) crc_err_d  = crc_err_q  + 8'd1;
               if (a_sync && (sync_err_q != 8'hFF)) sync_err_d = sync_err_q + 8'd1;
               if (a_len  && (len_err_q  != 8'hFF)) len_err_d  = len_err_q  + 8'd1;
            end
         end

         // Bank/counter registers
         always_ff @(posedge clock) begin
            if (reset) begin
               bank_valid_q  <= 1'b0;
               frame_cnt_q   <= '0;
               crc_err_q     <= '0;
               sync_err_q    <= '0;
               len_err_q     <= '0;
               bank_len_q    <= '0;
               bank_crc_q    <= '0;
               bank_pay_q    <= '{default: '0};
               pend_done_q   <= 1'b0;
               pend_crc_q    <= 1'b0;
               pend_sync_q   <= 1'b0;
               pend_len_q    <= 1'b0;
               frame_done_q  <= 1'b0;
               frame_error_q <= 1'b0;
            end else begin
               bank_valid_q  <= bank_valid_d;
               frame_cnt_q   <= frame_cnt_d;
               crc_err_q     <= crc_err_d;
               sync_err_q    <= sync_err_d;
               len_err_q     <= len_err_d;
               bank_len_q    <= bank_len_d;
               bank_crc_q    <= bank_crc_d;
               bank_pay_q    <= bank_pay_d;
               pend_done_q   <= pend_done_d;
               pend_crc_q    <= pend_crc_d;
               pend_sync_q   <= pend_sync_d;
               pend_len_q    <= pend_len_d;
               frame_done_q  <= frame_done_d;
               frame_error_q <= frame_error_d;
            end
         end

         // Readout word for this channel at the current word offset; bytes past length read 0
         always_comb begin
            rd_word = 32'd0;
            kb      = 6'd0;
            case (off)
               4'd0: rd_word = {frame_cnt_q, crc_err_q, sync_err_q[3:0], len_err_q[2:0], bank_valid_q};
               4'd1: rd_word = {16'b0, bank_len_q};
               4'd2: rd_word = bank_crc_q;
               default: begin
                  for (int j = 0; j < 4; j++) begin
                     kb = {off - 4'd3, 2'(j)};
                     if (({10'b0, kb} < bank_len_q) && (kb < PB_B)) rd_word[8*j +: 8] = bank_pay_q[PIW'(kb)];
                  end
               end
            endcase
         end

         assign ch_word[gi*32 +: 32] = rd_word;
         assign frame_done[gi]       = frame_done_q;
         assign frame_error[gi]      = frame_error_q;
      end
   endgenerate

   // Avalon read mux; out-of-range channels return a marker pattern
   always_comb begin
      readdata_d = readdata_q;
      if (read) begin
         readdata_d = 32'hDEADBEEF;
         for (int c = 0; c < NUM_LIGHTHOUSES; c++) begin
            if (ch_sel == ADDR_WIDTH'(c)) readdata_d = ch_word[c*32 +: 32];
         end
      end
   end

   // Registered read data, one cycle after read
   always_ff @(posedge clock) begin
      if (reset) readdata_q <= 32'd0;
      else       readdata_q <= readdata_d;
   end

endmodule

// File: tb/tb_ootx_multi_frame_decoder.sv
// Directed bench for ootx_multi_frame_decoder: builds OOTX bitstreams,
// drives them with 17-cycle strobe spacing and checks pulses and readout.
module tb_ootx_multi_frame_decoder;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  bit_valid, bit_data;
   logic [7:0]  address;
   logic        read, write;
   logic [31:0] readdata, writedata;
   logic        waitrequest;
   logic [1:0]  frame_done, frame_error;

   int checks = 0;
   int failures = 0;
   int done0 = 0, done1 = 0, err0 = 0, err1 = 0, both = 0;
   int sd0, sd1, se0, se1, sb;
   logic [31:0] rd;
   logic [7:0]  msg [64];
   bit          q0 [$];
   bit          q1 [$];

   ootx_multi_frame_decoder #(
      .NUM_LIGHTHOUSES(2), .MAX_PAYLOAD_BYTES(33), .ADDR_WIDTH(8)
   ) dut (
      .clock(clock), .reset(reset), .bit_valid(bit_valid), .bit_data(bit_data),
      .address(address), .read(read), .readdata(readdata), .write(write),
      .writedata(writedata), .waitrequest(waitrequest),
      .frame_done(frame_done), .frame_error(frame_error)
   );

   always #5 clock = ~clock;

   // pulse monitor, sampled away from the active edge
   always @(negedge clock) begin
      if (frame_done[0])  done0++;
      if (frame_done[1])  done1++;
      if (frame_error[0]) err0++;
      if (frame_error[1]) err1++;
      if (frame_done == 2'b11) both++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%08h", tag, got);
      end
   endtask

   task automatic add_bit(input int ch, input bit b);
      if (ch == 0) q0.push_back(b);
      else         q1.push_back(b);
   endtask

   task automatic add_zeros(input int ch, input int n);
      for (int i = 0; i < n; i++) add_bit(ch, 1'b0);
   endtask

   task automatic add_word(input int ch, input logic [15:0] w, input bit sync);
      for (int i = 15; i >= 0; i--) add_bit(ch, w[i]);
      add_bit(ch, sync);
   endtask

   // preamble, length word, nbytes of msg, two CRC words; bad_sync = word index whose sync is 0 (frame ends there)
   task automatic add_frame(input int ch, input int nzeros, input logic [15:0] len, input int nbytes,
                            input logic [31:0] crc, input int bad_sync);
      int idx;
      add_zeros(ch, nzeros);
      add_bit(ch, 1'b1);
      add_word(ch, {len[7:0], len[15:8]}, bad_sync != 0);
      if (bad_sync == 0) return;
      idx = 1;
      for (int p = 0; p < nbytes / 2; p++) begin
         add_word(ch, {msg[2*p], msg[2*p+1]}, bad_sync != idx);
         if (bad_sync == idx) return;
         idx++;
      end
      add_word(ch, {crc[7:0], crc[15:8]}, 1'b1);
      add_word(ch, {crc[23:16], crc[31:24]}, 1'b1);
   endtask

   task automatic load_msg(input string s, input logic [7:0] pad);
      for (int i = 0; i < s.len(); i++) msg[i] = s[i];
      msg[s.len()] = pad;
   endtask

   task automatic send_all();
      while ((q0.size() > 0) || (q1.size() > 0)) begin
         @(negedge clock);
         bit_valid = 2'b00;
         bit_data  = 2'b00;
         if (q0.size() > 0) begin bit_valid[0] = 1'b1; bit_data[0] = q0.pop_front(); end
         if (q1.size() > 0) begin bit_valid[1] = 1'b1; bit_data[1] = q1.pop_front(); end
         @(negedge clock);
         bit_valid = 2'b00;
         bit_data  = 2'b00;
         repeat (15) @(negedge clock);
      end
      repeat (4) @(negedge clock);
   endtask

   task automatic av_read(input logic [7:0] a, output logic [31:0] d);
      @(negedge clock);
      address = a;
      read    = 1'b1;
      @(negedge clock);
      read = 1'b0;
      d    = readdata;
   endtask

   task automatic av_write(input logic [7:0] a, input logic [31:0] wd);
      @(negedge clock);
      address   = a;
      writedata = wd;
      write     = 1'b1;
      @(negedge clock);
      write = 1'b0;
   endtask

   task automatic snap();
      sd0 = done0; sd1 = done1; se0 = err0; se1 = err1; sb = both;
   endtask

   initial begin
      reset = 1'b1; bit_valid = 2'b00; bit_data = 2'b00;
      address = 8'h00; read = 1'b0; write = 1'b0; writedata = 32'h0;
      repeat (3) @(negedge clock);
      check("rst_readdata", readdata, 32'h0);
      reset = 1'b0;
      @(negedge clock);
      check("rst_pulses", {28'h0, frame_done, frame_error}, 32'h0);
      av_read(8'd0, rd);  check("rst_status0", rd, 32'h0);
      av_read(8'd16, rd); check("rst_status1", rd, 32'h0);

      // bad CRC on a fresh channel
      load_msg("123456789", 8'h00);
      add_frame(0, 17, 16'd9, 10, 32'hCBF43927, -1);
      snap(); send_all();
      check("badcrc_done", done0 - sd0, 0);
      check("badcrc_err", err0 - se0, 1);
      av_read(8'd0, rd); check("badcrc_status", rd, 32'h00000100);
      av_read(8'd2, rd); check("badcrc_crcword", rd, 32'h0);

      av_write(8'd0, 32'h1);
      av_read(8'd0, rd); check("clear_status", rd, 32'h0);

      // good frame "123456789"
      add_frame(0, 17, 16'd9, 10, 32'hCBF43926, -1);
      snap(); send_all();
      check("good_done", done0 - sd0, 1);
      check("good_err", err0 - se0, 0);
      av_read(8'd0, rd); check("good_status", rd, 32'h00010001);
      av_read(8'd1, rd); check("good_len", rd, 32'd9);
      av_read(8'd2, rd); check("good_crc", rd, 32'hCBF43926);
      av_read(8'd3, rd); check("good_w3", rd, 32'h34333231);
      av_read(8'd4, rd); check("good_w4", rd, 32'h38373635);
      av_read(8'd5, rd); check("good_w5", rd, 32'h00000039);
      av_read(8'd6, rd); check("good_w6", rd, 32'h0);

      // length 40 rejected, then "abc" with nonzero pad
      av_write(8'd0, 32'h1);
      add_zeros(0, 17); add_bit(0, 1'b1); add_word(0, 16'h2800, 1'b1);
      load_msg("abc", 8'h5A);
      add_frame(0, 17, 16'd3, 4, 32'h352441C2, -1);
      snap(); send_all();
      check("len_err_pulse", err0 - se0, 1);
      check("len_done", done0 - sd0, 1);
      av_read(8'd0, rd); check("len_status", rd, 32'h00010003);
      av_read(8'd1, rd); check("abc_len", rd, 32'd3);
      av_read(8'd2, rd); check("abc_crc", rd, 32'h352441C2);
      av_read(8'd3, rd); check("abc_w3_padmask", rd, 32'h00636261);
      av_read(8'd4, rd); check("abc_w4_stale", rd, 32'h0);

      // sync fault after second payload word, then "a"
      av_write(8'd0, 32'h1);
      load_msg("123456789", 8'h00);
      add_frame(0, 17, 16'd9, 10, 32'hCBF43926, 2);
      load_msg("a", 8'h77);
      add_frame(0, 17, 16'd1, 2, 32'hE8B7BE43, -1);
      snap(); send_all();
      check("sync_err_pulse", err0 - se0, 1);
      check("sync_done", done0 - sd0, 1);
      av_read(8'd0, rd); check("sync_status", rd, 32'h00010011);
      av_read(8'd1, rd); check("a_len", rd, 32'd1);
      av_read(8'd2, rd); check("a_crc", rd, 32'hE8B7BE43);
      av_read(8'd3, rd); check("a_w3", rd, 32'h00000061);

      // both channels, frames ending on the same strobe
      load_msg("123456789", 8'h00);
      add_frame(0, 17, 16'd9, 10, 32'hCBF43926, -1);
      load_msg("abc", 8'h00);
      add_frame(1, 68, 16'd3, 4, 32'h352441C2, -1);
      snap(); send_all();
      check("dual_same_cycle", both - sb, 1);
      check("dual_done0", done0 - sd0, 1);
      check("dual_done1", done1 - sd1, 1);
      check("dual_err1", err1 - se1, 0);
      av_read(8'd16, rd); check("ch1_status", rd, 32'h00010001);
      av_read(8'd17, rd); check("ch1_len", rd, 32'd3);
      av_read(8'd18, rd); check("ch1_crc", rd, 32'h352441C2);
      av_read(8'd19, rd); check("ch1_w3", rd, 32'h00636261);
      av_read(8'h20, rd); check("unmapped", rd, 32'hDEADBEEF);
      av_read(8'd0, rd);  check("ch0_status_dual", rd, 32'h00020011);

      // reset mid-payload, then a full frame
      load_msg("123456789", 8'h00);
      add_zeros(0, 17); add_bit(0, 1'b1);
      add_word(0, 16'h0900, 1'b1); add_word(0, 16'h3132, 1'b1); add_word(0, 16'h3334, 1'b1);
      send_all();
      @(negedge clock); reset = 1'b1;
      repeat (2) @(negedge clock); reset = 1'b0;
      av_read(8'd0, rd);  check("mid_rst_status0", rd, 32'h0);
      av_read(8'd16, rd); check("mid_rst_status1", rd, 32'h0);
      load_msg("abc", 8'h00);
      add_frame(0, 17, 16'd3, 4, 32'h352441C2, -1);
      snap(); send_all();
      check("post_rst_done", done0 - sd0, 1);
      check("post_rst_err", err0 - se0, 0);
      av_read(8'd0, rd); check("post_rst_status", rd, 32'h00010001);
      av_read(8'd1, rd); check("post_rst_len", rd, 32'd3);
      av_write(8'd0, 32'h1);
      av_read(8'd0, rd); check("final_clear", rd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ootx_multi_frame_decoder.md
Name: ootx_multi_frame_decoder

Overview:
Parameterised OOTX frame decoder for NUM_LIGHTHOUSES independent lighthouse bitstreams. Upstream sweep/sync decoders deliver one OOTX data bit per sync pulse per channel. Per channel, this block:
- detects the preamble,
- strips the sync bits,
- captures the length, payload and CRC32,
- verifies the CRC32.

A frame that passes the CRC is committed atomically into a per-channel readout bank. All banks and per-channel status/error counters are exposed on an Avalon-MM slave with fixed read latency 1.

Parameters:
NUM_LIGHTHOUSES, 2, number of independent channels (1..8).
MAX_PAYLOAD_BYTES, 33, largest accepted payload length in bytes (1..52).
ADDR_WIDTH, 8, Avalon word-address width; must satisfy NUM_LIGHTHOUSES*16 <= 2^ADDR_WIDTH.

Ports:
clock  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
bit_valid  in  NUM_LIGHTHOUSES  one-cycle strobe per channel; a new OOTX bit is present.
bit_data  in  NUM_LIGHTHOUSES  OOTX bit value, sampled when the matching bit_valid is high.
address  in  ADDR_WIDTH  Avalon word address.
read  in  1  Avalon read.
readdata  out  32  Avalon read data, valid exactly 1 cycle after read.
write  in  1  Avalon write.
writedata  in  32  Avalon write data.
waitrequest  out  1  tied to 0.
frame_done  out  NUM_LIGHTHOUSES  one-cycle pulse when a CRC-good frame is committed.
frame_error  out  NUM_LIGHTHOUSES  one-cycle pulse on sync, length or CRC error.

Behaviour:
- Reset (synchronous): all FSMs go to HUNT; zero counters, counters and banks clear to 0; readdata=0; frame_done=0; frame_error=0.
- Per-channel zero counter:
  - counts consecutive 0 bits, saturating at 17.
  - cleared by any 1 bit.
- Preamble: a 1 bit arriving while the zero counter is >=17 starts a frame.
  - This applies in every state.
  - If the channel was mid-frame, the partial frame is discarded, sync_err_cnt increments and frame_error pulses.
- Word format after the preamble: 16 data bits MSB-first, then 1 sync bit that must be 1. The first byte of each word is its high byte.
- Sync bit = 0 outside the preamble case: go to HUNT, sync_err_cnt increments, frame_error pulses.
- FSM states HUNT -> LENGTH -> PAYLOAD -> CRC -> CHECK -> HUNT.
- LENGTH:
  - one word; length = {byte1, byte0} (little-endian).
  - length = 0 or length > MAX_PAYLOAD_BYTES: HUNT, len_err_cnt++, frame_error pulses.
- PAYLOAD: ceil(length/2) words; the odd pad byte is stored but excluded from the CRC.
- CRC:
  - two words, bytes in order c0..c3.
  - received crc = {c3,c2,c1,c0}.
- CRC32 algorithm: reflected, poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, computed over exactly `length` payload bytes, each byte LSB-first.
  - May be computed serially (8 cycles per byte).
  - Must finish before the next bit_valid; the minimum spacing between bit_valid strobes is 16 cycles.
- CHECK (1 cycle):
  - match: copy length, received crc and payload into the bank in the same cycle; set valid=1; frame_cnt++; frame_done pulses.
  - mismatch: bank unchanged; crc_err_cnt++; frame_error pulses.
- Channels operate fully independently; simultaneous strobes on all channels must be handled in the same cycle.
- Counters: frame_cnt 16 bit wraps at 0xFFFF->0; error counters 8 bit saturate at 0xFF.
- Address map: channel c occupies word addresses c*16 .. c*16+15.
  - +0 status: {frame_cnt[15:0], crc_err_cnt[7:0], sync_err_cnt[3:0] (low 4 bits), len_err_cnt[2:0] (low 3 bits), valid}.
  - +1: {16'b0, length}.
  - +2: crc32.
  - +3..+15: payload bytes packed little-endian; byte k is in word 3+k/4, bits 8*(k%4)+7 : 8*(k%4).
  - Bytes beyond length read 0.
  - Unmapped or out-of-range addresses read 0xDEADBEEF.
- Read coherence: a read in the same cycle as a commit returns the pre-commit value. A multi-word read sequence is coherent only if frame_cnt is unchanged across it (software rereads +0).
- Write to +0 with writedata[0]=1 clears valid, frame_cnt and all error counters of that channel.
  - Same-cycle commit or error: the clear wins, then the new event applies in the following cycle.
  - Writes to any other address are ignored.

Test Plan:
- Ch0: 17 zeros, 1, then length 9 and payload "123456789" plus a 0x00 pad byte, CRC 0xCBF43926 with correct sync bits -> frame_done[0] pulse; +1 reads 9; +2 reads 0xCBF43926; +3 reads 0x34333231; +5 reads 0x00000039; status reads 0x00010001.
- Same frame with CRC 0xCBF43927 -> frame_error pulse; crc_err_cnt=1; valid stays 0; +2 reads 0.
- Length word 40 with MAX_PAYLOAD_BYTES=33 -> HUNT; len_err_cnt=1; a valid frame sent immediately after still decodes.
- Sync bit forced 0 after the 2nd payload word, then a new valid frame -> sync_err_cnt=1, second frame committed, frame_cnt=1.
- Valid frames on ch0 and ch1 with bit_valid asserted in the same cycles -> both frame_done pulse in the same cycle; addresses 16..18 hold ch1 data; address 0x20 reads 0xDEADBEEF.
- Reset asserted mid-PAYLOAD, then a full frame -> no commit from the aborted frame; exactly one commit afterwards; write 1 to address 0 -> status reads 0.
